alu_command_queue: RTL and testbench

- Upstream stage of the ALU controller.
- Buffers 12-bit ALU commands from the host side in a small FIFO.
- Issues them one at a time to the controller: presents `command` stable and pulses `run` for one cycle, then waits for the controller's `done` before issuing the next.
- Watchdog timer: flags a controller that never answers and recovers the queue.

---
 rtl/alu_command_queue_if.sv | 29 ++
 rtl/alu_command_queue.sv | 129 ++++++++++++
 tb/tb_alu_command_queue.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_command_queue_if.sv
// Host/controller-facing signal bundle for the ALU command queue.
interface alu_command_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [11:0]   cmd_in;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          flush;
  logic [11:0]   command;
  logic          run;
  logic          done;
  logic          busy;
  logic [CW-1:0] count;
  logic          timeout_err;

  // Host and controller side: drives commands, flush and done.
  modport master (
    output cmd_in, cmd_valid, flush, done,
    input  cmd_ready, command, run, busy, count, timeout_err
  );

  // Queue side.
  modport slave (
    input  cmd_in, cmd_valid, flush, done,
    output cmd_ready, command, run, busy, count, timeout_err
  );
endinterface

// File: rtl/alu_command_queue.sv
// ALU command queue: FIFO of 12-bit commands issued one at a time to the
// controller with a run strobe, waiting for done, guarded by a watchdog.
module alu_command_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input logic            clk,
  input logic            rst_n,
  alu_command_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d, err_set;
  logic          ready_q, run_q, busy_q;
  logic [11:0]   command_q;
  logic [11:0]   mem [DEPTH];
  logic          push, pop;

  // Flush discards any push in the same cycle; a full queue never accepts.
  assign push = bus.cmd_valid && (count_q != CW'(DEPTH)) && !bus.flush;

  // Next-state logic: pop on leaving IDLE, watchdog while waiting for done.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.done) begin
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; flush overrides push, pop and the sticky error.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    err_d   = err_q | err_set;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (bus.flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  // FSM state and watchdog timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      command_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      err_q   <= err_d;
      ready_q <= (count_d != CW'(DEPTH));
      run_q   <= (state_d == ISSUE);
      busy_q  <= (state_d != IDLE);
      if (pop) command_q <= mem[rd_q];
    end
  end

  // Storage array; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= bus.cmd_in;
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.count       = count_q;
  assign bus.timeout_err = err_q;
  assign bus.run         = run_q;
  assign bus.busy        = busy_q;
  assign bus.command     = command_q;
endmodule

// File: tb/tb_alu_command_queue.sv
// Scoreboard bench for alu_command_queue.
module tb_alu_command_queue;
  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  int   run_count;
  int   cyc;
  logic [11:0] sb[$];

  alu_command_queue_if #(.DEPTH(8)) bus ();

  alu_command_queue #(.DEPTH(8), .TIMEOUT(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.run === 1'b1) run_count <= run_count + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.run === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Pop expected commands as they issue; done returned in the first WAIT cycle.
  task automatic serve(input int n);
    bit seen;
    logic [11:0] exp;
    for (int i = 0; i < n; i++) begin
      wait_run(200, seen);
      checks++;
      if (!seen) begin
        fails++;
        $display("FAIL serve_run_timeout entry=%0d actual=no_run required=run", i);
      end
      exp = (sb.size() != 0) ? sb.pop_front() : 12'hFFF;
      checks++;
      if (bus.command !== exp) begin
        fails++;
        $display("FAIL serve_order entry=%0d actual=%h required=%h", i, bus.command, exp);
      end
      step();
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.command, bus.run, bus.busy, bus.timeout_err, bus.cmd_ready, bus.count} !== {12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      fails++;
      $display("FAIL reset_outputs actual cmd=%h run=%b busy=%b err=%b rdy=%b cnt=%0d required 000/0/0/0/1/0",
               bus.command, bus.run, bus.busy, bus.timeout_err, bus.cmd_ready, bus.count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int r0;
    r0 = run_count;
    bus.cmd_in = 12'hA5C; bus.cmd_valid = 1'b1; sb.push_back(12'hA5C);
    step();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.count !== 4'd1 || bus.run !== 1'b0) begin
      fails++;
      $display("FAIL single_after_push actual cnt=%0d run=%b required cnt=1 run=0", bus.count, bus.run);
    end
    step();
    checks++;
    if (bus.run !== 1'b1 || bus.busy !== 1'b1 || bus.count !== 4'd0) begin
      fails++;
      $display("FAIL single_issue actual run=%b busy=%b cnt=%0d required 1/1/0", bus.run, bus.busy, bus.count);
    end
    checks++;
    if (bus.command !== sb.pop_front()) begin
      fails++;
      $display("FAIL single_command actual=%h required=a5c", bus.command);
    end
    step();
    checks++;
    if (bus.run !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL single_run_width actual run=%b busy=%b required run=0 busy=1", bus.run, bus.busy);
    end
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.command !== 12'hA5C || bus.count !== 4'd0 || run_count - r0 != 1) begin
      fails++;
      $display("FAIL single_complete actual busy=%b cmd=%h cnt=%0d runs=%0d required 0/a5c/0/1",
               bus.busy, bus.command, bus.count, run_count - r0);
    end
  endtask

  task automatic test_fill_order();
    int r0;
    r0 = run_count;
    for (int i = 1; i <= 9; i++) begin
      bus.cmd_in = 12'(i); bus.cmd_valid = 1'b1; sb.push_back(12'(i));
      step();
      if (i == 2) begin
        checks++;
        if (bus.run !== 1'b1 || bus.command !== sb.pop_front()) begin
          fails++;
          $display("FAIL fill_first_issue actual run=%b cmd=%h required run=1 cmd=001", bus.run, bus.command);
        end
      end
      if (i == 8) begin
        checks++;
        if (bus.count !== 4'd7) begin
          fails++;
          $display("FAIL fill_count7 actual=%0d required=7", bus.count);
        end
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.count !== 4'd8 || bus.cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full actual cnt=%0d rdy=%b required cnt=8 rdy=0", bus.count, bus.cmd_ready);
    end
    // Full queue with valid held: blocked push while a pop happens.
    bus.cmd_in = 12'h00A; bus.cmd_valid = 1'b1; bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++;
    if (bus.count !== 4'd8 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL full_hold_done actual cnt=%0d busy=%b required cnt=8 busy=0", bus.count, bus.busy);
    end
    step();
    checks++;
    if (bus.count !== 4'd7 || bus.cmd_ready !== 1'b1 || bus.run !== 1'b1) begin
      fails++;
      $display("FAIL full_pop_no_push actual cnt=%0d rdy=%b run=%b required 7/1/1", bus.count, bus.cmd_ready, bus.run);
    end
    checks++;
    if (bus.command !== sb.pop_front()) begin
      fails++;
      $display("FAIL full_pop_command actual=%h required=002", bus.command);
    end
    step();
    sb.push_back(12'h00A);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.count !== 4'd8) begin
      fails++;
      $display("FAIL full_next_push actual cnt=%0d required=8", bus.count);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    serve(8);
    checks++;
    if (bus.count !== 4'd0 || sb.size() != 0 || run_count - r0 != 10) begin
      fails++;
      $display("FAIL fill_drain actual cnt=%0d left=%0d runs=%0d required 0/0/10", bus.count, sb.size(), run_count - r0);
    end
  endtask

  task automatic test_back_to_back();
    int t[3];
    bit seen;
    bus.cmd_in = 12'h0B0; bus.cmd_valid = 1'b1; sb.push_back(12'h0B0);
    step();
    bus.cmd_in = 12'h0B1; sb.push_back(12'h0B1);
    step();
    checks++;
    if (bus.run !== 1'b1 || bus.command !== sb.pop_front()) begin
      fails++;
      $display("FAIL b2b_first actual run=%b cmd=%h required run=1 cmd=0b0", bus.run, bus.command);
    end
    bus.cmd_in = 12'h0B2; sb.push_back(12'h0B2);
    step();
    bus.cmd_in = 12'h0B3; sb.push_back(12'h0B3);
    step();
    bus.cmd_valid = 1'b0;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_run(20, seen);
      t[i] = cyc;
      checks++;
      if (!seen || bus.command !== sb.pop_front()) begin
        fails++;
        $display("FAIL b2b_issue entry=%0d actual seen=%b cmd=%h required seen=1 cmd=0b%0d", i, seen, bus.command, i + 1);
      end
      step();
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
    end
    checks++;
    if (t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
      fails++;
      $display("FAIL b2b_spacing actual=%0d,%0d required=3,3", t[1] - t[0], t[2] - t[1]);
    end
  endtask

  task automatic test_timeout();
    bus.cmd_in = 12'h3F0; bus.cmd_valid = 1'b1; sb.push_back(12'h3F0);
    step();
    bus.cmd_in = 12'h3F1; sb.push_back(12'h3F1);
    step();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.run !== 1'b1 || bus.command !== sb.pop_front()) begin
      fails++;
      $display("FAIL to_issue actual run=%b cmd=%h required run=1 cmd=3f0", bus.run, bus.command);
    end
    repeat (64) step();
    checks++;
    if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL to_before_expiry actual busy=%b err=%b required busy=1 err=0", bus.busy, bus.timeout_err);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL to_expired actual busy=%b err=%b required busy=0 err=1", bus.busy, bus.timeout_err);
    end
    step();
    checks++;
    if (bus.run !== 1'b1 || bus.command !== sb.pop_front() || bus.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL to_next_issue actual run=%b cmd=%h err=%b required 1/3f1/1", bus.run, bus.command, bus.timeout_err);
    end
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL to_flush_clear actual err=%b required err=0", bus.timeout_err);
    end
  endtask

  task automatic test_done_at_expiry();
    bus.cmd_in = 12'h155; bus.cmd_valid = 1'b1; sb.push_back(12'h155);
    step();
    bus.cmd_valid = 1'b0;
    step();
    checks++;
    if (bus.run !== 1'b1 || bus.command !== sb.pop_front()) begin
      fails++;
      $display("FAIL expiry_issue actual run=%b cmd=%h required run=1 cmd=155", bus.run, bus.command);
    end
    repeat (64) step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL expiry_done_wins actual err=%b busy=%b required err=0 busy=0", bus.timeout_err, bus.busy);
    end
  endtask

  task automatic test_flush();
    int r0;
    for (int i = 1; i <= 4; i++) begin
      bus.cmd_in = 12'h100 + 12'(i); bus.cmd_valid = 1'b1;
      step();
    end
    checks++;
    if (bus.count !== 4'd3 || bus.busy !== 1'b1 || bus.command !== 12'h101) begin
      fails++;
      $display("FAIL flush_setup actual cnt=%0d busy=%b cmd=%h required 3/1/101", bus.count, bus.busy, bus.command);
    end
    r0 = run_count;
    bus.cmd_in = 12'h1FF; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.cmd_valid = 1'b0;
    checks++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b1 || bus.command !== 12'h101 || bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_clear actual cnt=%0d busy=%b cmd=%h rdy=%b required 0/1/101/1",
               bus.count, bus.busy, bus.command, bus.cmd_ready);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    repeat (10) step();
    checks++;
    if (bus.busy !== 1'b0 || bus.count !== 4'd0 || run_count != r0) begin
      fails++;
      $display("FAIL flush_no_reissue actual busy=%b cnt=%0d runs=%0d required 0/0/0", bus.busy, bus.count, run_count - r0);
    end
    // Flush coinciding with the pop: the loaded command still issues.
    bus.cmd_in = 12'h111; bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.count !== 4'd0 || bus.run !== 1'b1 || bus.command !== 12'h111) begin
      fails++;
      $display("FAIL flush_with_pop actual cnt=%0d run=%b cmd=%h required 0/1/111", bus.count, bus.run, bus.command);
    end
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int r0;
    bus.cmd_in = 12'h222; bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    r0 = run_count;
    checks++;
    if ({bus.command, bus.run, bus.busy, bus.timeout_err, bus.cmd_ready, bus.count} !== {12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      fails++;
      $display("FAIL reset_mid_wait actual cmd=%h run=%b busy=%b err=%b rdy=%b cnt=%0d required 000/0/0/0/1/0",
               bus.command, bus.run, bus.busy, bus.timeout_err, bus.cmd_ready, bus.count);
    end
    step();
    rst_n = 1'b1;
    repeat (10) step();
    checks++;
    if (run_count != r0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_abandon actual runs=%0d busy=%b required 0/0", run_count - r0, bus.busy);
    end
  endtask

  initial begin
    checks = 0; fails = 0; run_count = 0; cyc = 0;
    rst_n = 1'b0;
    bus.cmd_in = '0; bus.cmd_valid = 1'b0; bus.flush = 1'b0; bus.done = 1'b0;
    test_reset();
    test_single();
    test_fill_order();
    test_back_to_back();
    test_timeout();
    test_done_at_expiry();
    test_flush();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1, "bench time limit reached");
  end
endmodule
